dot_product_ctrl: RTL and testbench

//  Sequencer for the two Dual_SRAM vector stores (A and B) in the dot-product datapath.
//  - Gates host loads into A/B, issues a single-cycle memory clear on request.
//  - On Start, streams addresses 0..Vec_Len-1 to both SRAMs and multiply-accumulates the returned words.
//  - Presents the registered result with a one-cycle Done pulse; sole owner of SRAM control pins.

---
 rtl/dot_ctrl_pkg.sv | 17 +
 rtl/dot_product_ctrl_mac.sv | 38 +++
 rtl/dot_product_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dot_product_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_ctrl_pkg.sv
// Shared types and width helpers for the dot-product sequencer.
package dot_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Accumulator width that can hold Ram_Depth full-scale unsigned products.
  function automatic int acc_width_calc(input int data_w, input int addr_w);
    return 2 * data_w + addr_w + 1;
  endfunction

endpackage

// File: rtl/dot_product_ctrl_mac.sv
// Multiply-accumulate for the dot-product datapath: unsigned operands,
// accumulate gated by the delayed read-valid, synchronous clear on Start.
module dot_mac
  import dot_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int ACC_W  = acc_width_calc(DATA_W, ADDR_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              vld_p1,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  acc_nxt
);

  logic [2*DATA_W-1:0] prod_p1;

  // Stage p1: SRAM words arrive one cycle after the read; product and next sum
  always_comb begin
    prod_p1 = data_a * data_b;
    acc_nxt = vld_p1 ? (acc + ACC_W'(prod_p1)) : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/dot_product_ctrl.sv
// Sequencer for the A/B vector SRAMs: gates host loads, issues memory clears,
// streams read addresses on Start and reports the accumulated dot product.
module dot_product_ctrl
  import dot_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int ACC_W  = acc_width_calc(DATA_W, ADDR_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Start,
  input  logic              Clear_Req,
  input  logic [ADDR_W:0]   Vec_Len,
  input  logic              Load_Valid,
  input  logic              Load_Sel,
  input  logic [ADDR_W-1:0] Load_Addr,
  input  logic [DATA_W-1:0] Load_Data,
  output logic              Load_Ready,
  output logic              Mem_Clear,
  output logic              Chip_Select,
  output logic              En_Write_A,
  output logic              En_Write_B,
  output logic [ADDR_W-1:0] Write_Addr,
  output logic [DATA_W-1:0] Write_Data,
  output logic              En_Read,
  output logic [ADDR_W-1:0] Read_Addr,
  input  logic [DATA_W-1:0] Read_Data_A,
  input  logic [DATA_W-1:0] Read_Data_B,
  output logic              Busy,
  output logic              Done,
  output logic [ACC_W-1:0]  Result
);

  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_nxt;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   len_clamp;
  logic              vld_p1;
  logic              acc_clr;
  logic              wr_ok;
  logic              start_ok;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_nxt;

  assign len_clamp = (Vec_Len > DEPTH_L) ? DEPTH_L : Vec_Len;

  // Stage p0: FSM decode, SRAM control and read address issue
  always_comb begin
    state_nxt   = state;
    acc_clr     = 1'b0;
    wr_ok       = 1'b0;
    start_ok    = 1'b0;
    Load_Ready  = 1'b0;
    Mem_Clear   = 1'b0;
    Chip_Select = 1'b0;
    En_Write_A  = 1'b0;
    En_Write_B  = 1'b0;
    Write_Addr  = '0;
    Write_Data  = '0;
    En_Read     = 1'b0;
    Read_Addr   = '0;
    Done        = 1'b0;
    Busy        = (state != IDLE);

    case (state)
      IDLE: begin
        // A clear request takes priority over both loads and Start.
        Load_Ready  = !Clear_Req;
        wr_ok       = Load_Valid && !Clear_Req;
        Chip_Select = wr_ok;
        En_Write_A  = wr_ok && !Load_Sel;
        En_Write_B  = wr_ok && Load_Sel;
        Write_Addr  = wr_ok ? Load_Addr : '0;
        Write_Data  = wr_ok ? Load_Data : '0;
        if (Clear_Req) begin
          state_nxt = CLEAR;
        end else if (Start) begin
          start_ok = 1'b1;
          acc_clr  = 1'b1;
          state_nxt = (Vec_Len == '0) ? DONE : READ;
        end
      end
      CLEAR: begin
        Mem_Clear = 1'b1;
        state_nxt = IDLE;
      end
      READ: begin
        Chip_Select = 1'b1;
        En_Read     = 1'b1;
        Read_Addr   = idx[ADDR_W-1:0];
        if (idx == len - 1'b1) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = DONE;
      end
      DONE: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Keep every pin quiet while reset is held, including the IDLE handshake.
    if (!rst_n) begin
      Load_Ready  = 1'b0;
      Mem_Clear   = 1'b0;
      Chip_Select = 1'b0;
      En_Write_A  = 1'b0;
      En_Write_B  = 1'b0;
      Write_Addr  = '0;
      Write_Data  = '0;
      En_Read     = 1'b0;
      Read_Addr   = '0;
      Done        = 1'b0;
      Busy        = 1'b0;
    end
  end

  // Stage p0 -> p1: state, address counter, read-valid delay and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      len    <= '0;
      vld_p1 <= 1'b0;
      Result <= '0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= En_Read;
      if (start_ok) begin
        len <= len_clamp;
        idx <= '0;
      end else if (state == READ) begin
        idx <= idx + 1'b1;
      end
      // acc_nxt already includes the last word arriving on the DRAIN edge.
      if (state_nxt == DONE && state != DONE) begin
        Result <= (state == IDLE) ? '0 : acc_nxt;
      end
    end
  end

  dot_mac #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (acc_clr),
    .vld_p1  (vld_p1),
    .data_a  (Read_Data_A),
    .data_b  (Read_Data_B),
    .acc     (acc),
    .acc_nxt (acc_nxt)
  );

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Directed bench for dot_product_ctrl with behavioural A/B SRAMs and a result scoreboard.
module tb_dot_product_ctrl;
  import dot_ctrl_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int ACCW  = acc_width_calc(DW, AW);

  logic            clk;
  logic            rst_n;
  logic            Start;
  logic            Clear_Req;
  logic [AW:0]     Vec_Len;
  logic            Load_Valid;
  logic            Load_Sel;
  logic [AW-1:0]   Load_Addr;
  logic [DW-1:0]   Load_Data;
  logic            Load_Ready;
  logic            Mem_Clear;
  logic            Chip_Select;
  logic            En_Write_A;
  logic            En_Write_B;
  logic [AW-1:0]   Write_Addr;
  logic [DW-1:0]   Write_Data;
  logic            En_Read;
  logic [AW-1:0]   Read_Addr;
  logic [DW-1:0]   Read_Data_A;
  logic [DW-1:0]   Read_Data_B;
  logic            Busy;
  logic            Done;
  logic [ACCW-1:0] Result;

  dot_product_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Start       (Start),
    .Clear_Req   (Clear_Req),
    .Vec_Len     (Vec_Len),
    .Load_Valid  (Load_Valid),
    .Load_Sel    (Load_Sel),
    .Load_Addr   (Load_Addr),
    .Load_Data   (Load_Data),
    .Load_Ready  (Load_Ready),
    .Mem_Clear   (Mem_Clear),
    .Chip_Select (Chip_Select),
    .En_Write_A  (En_Write_A),
    .En_Write_B  (En_Write_B),
    .Write_Addr  (Write_Addr),
    .Write_Data  (Write_Data),
    .En_Read     (En_Read),
    .Read_Addr   (Read_Addr),
    .Read_Data_A (Read_Data_A),
    .Read_Data_B (Read_Data_B),
    .Busy        (Busy),
    .Done        (Done),
    .Result      (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM pair with 1-cycle read latency
  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];

  always @(posedge clk) begin
    if (Mem_Clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
    end else if (Chip_Select) begin
      if (En_Write_A) mem_a[Write_Addr] <= Write_Data;
      if (En_Write_B) mem_b[Write_Addr] <= Write_Data;
      if (En_Read) begin
        Read_Data_A <= mem_a[Read_Addr];
        Read_Data_B <= mem_b[Read_Addr];
      end
    end
  end

  // Activity monitors, sampled mid-cycle
  int rd_hits [DEPTH];
  int rd_total;
  int wr_total;
  int clr_total;
  int done_total;

  always @(negedge clk) begin
    if (Chip_Select && En_Read) begin
      rd_hits[Read_Addr] = rd_hits[Read_Addr] + 1;
      rd_total = rd_total + 1;
    end
    if (En_Write_A || En_Write_B) wr_total = wr_total + 1;
    if (Mem_Clear) clr_total = clr_total + 1;
    if (Done) done_total = done_total + 1;
  end

  // Shadow copy of intended SRAM contents and the scoreboard
  logic [DW-1:0]   sh_a [DEPTH];
  logic [DW-1:0]   sh_b [DEPTH];
  logic [ACCW-1:0] exp_q [$];
  int checks;
  int errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [ACCW-1:0] model_dot(input int vlen);
    longint s;
    int l;
    s = 0;
    l = (vlen > DEPTH) ? DEPTH : vlen;
    for (int i = 0; i < l; i++) s += longint'(sh_a[i]) * longint'(sh_b[i]);
    return ACCW'(s);
  endfunction

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic load(input logic sel, input int addr, input int data);
    Load_Valid = 1'b1;
    Load_Sel   = sel;
    Load_Addr  = AW'(addr);
    Load_Data  = DW'(data);
    @(posedge clk); #1;
    Load_Valid = 1'b0;
    if (sel) sh_b[addr] = DW'(data);
    else     sh_a[addr] = DW'(data);
  endtask

  task automatic run_dot(input int vlen, input string tag);
    int l;
    int rd0;
    int cyc;
    logic [ACCW-1:0] exp;
    l   = (vlen > DEPTH) ? DEPTH : vlen;
    rd0 = rd_total;
    exp_q.push_back(model_dot(vlen));
    Vec_Len = (AW+1)'(vlen);
    Start   = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    @(negedge clk);
    if (vlen != 0) chk({tag, "_busy"}, 64'(Busy), 64'd1);
    cyc = 0;
    while (!Done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    exp = exp_q.pop_front();
    if (!Done) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({tag, "_latency"}, 64'(cyc), (vlen == 0) ? 64'd0 : 64'(l + 1));
      chk({tag, "_result"}, 64'(Result), 64'(exp));
      chk({tag, "_reads"}, 64'(rd_total - rd0), 64'(l));
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(Done), 64'd0);
    chk({tag, "_idle"}, 64'(Busy), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int w0;
    int c0;
    int d0;
    int bad;
    int hits0 [DEPTH];
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    Start = 1'b0;
    Clear_Req = 1'b0;
    Vec_Len = '0;
    Load_Valid = 1'b0;
    Load_Sel = 1'b0;
    Load_Addr = '0;
    Load_Data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sh_a[i] = '0;
      sh_b[i] = '0;
    end

    // Reset state
    @(negedge clk);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_result", 64'(Result), 64'd0);
    chk("rst_load_ready", 64'(Load_Ready), 64'd0);
    chk("rst_cs", 64'(Chip_Select), 64'd0);
    chk("rst_en_read", 64'(En_Read), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Load handshake and basic dot product
    Load_Valid = 1'b1; Load_Sel = 1'b0; Load_Addr = '0; Load_Data = 8'd1;
    @(negedge clk);
    chk("load_ready", 64'(Load_Ready), 64'd1);
    chk("load_we_a", 64'({En_Write_A, En_Write_B, Chip_Select}), 64'b101);
    @(posedge clk); #1;
    Load_Valid = 1'b0;
    sh_a[0] = 8'd1;
    for (int i = 1; i < 4; i++) load(1'b0, i, i + 1);
    for (int i = 0; i < 4; i++) load(1'b1, i, i + 5);
    run_dot(4, "basic");
    chk("basic_model70", 64'(model_dot(4)), 64'd70);

    // Zero-length vector
    run_dot(0, "len0");

    // Full-scale operands over the whole depth
    for (int i = 0; i < DEPTH; i++) begin
      load(1'b0, i, 255);
      load(1'b1, i, 255);
    end
    run_dot(16, "full");
    chk("full_model", 64'(model_dot(16)), 64'd1040400);

    // Oversized length clamps to the depth, every address read once
    for (int i = 0; i < DEPTH; i++) load(1'b0, i, i + 1);
    for (int i = 0; i < DEPTH; i++) hits0[i] = rd_hits[i];
    run_dot(20, "clamp");
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (rd_hits[i] - hits0[i] != 1) bad++;
    chk("clamp_addr_once", 64'(bad), 64'd0);

    // Clear wins over Start and a load in the same cycle
    w0 = wr_total;
    c0 = clr_total;
    Clear_Req = 1'b1; Start = 1'b1; Vec_Len = 5'd4;
    Load_Valid = 1'b1; Load_Sel = 1'b0; Load_Addr = '0; Load_Data = 8'd99;
    @(negedge clk);
    chk("clr_load_ready", 64'(Load_Ready), 64'd0);
    chk("clr_no_cs", 64'(Chip_Select), 64'd0);
    @(posedge clk); #1;
    Clear_Req = 1'b0; Start = 1'b0; Load_Valid = 1'b0;
    @(negedge clk);
    chk("clr_pulse", 64'({Mem_Clear, Chip_Select, Busy}), 64'b101);
    @(posedge clk); #1;
    @(negedge clk);
    chk("clr_back_idle", 64'({Mem_Clear, Busy}), 64'b00);
    chk("clr_count", 64'(clr_total - c0), 64'd1);
    chk("clr_no_write", 64'(wr_total - w0), 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) begin
      sh_a[i] = '0;
      sh_b[i] = '0;
    end
    run_dot(4, "after_clr");

    // Start, Clear_Req and loads during READ are ignored
    for (int i = 0; i < 4; i++) load(1'b0, i, i + 1);
    for (int i = 0; i < 4; i++) load(1'b1, i, i + 5);
    w0 = wr_total;
    c0 = clr_total;
    d0 = done_total;
    exp_q.push_back(model_dot(8));
    Vec_Len = 5'd8; Start = 1'b1;
    @(posedge clk); #1;
    Vec_Len = 5'd2; Clear_Req = 1'b1;
    Load_Valid = 1'b1; Load_Sel = 1'b1; Load_Addr = 4'd2; Load_Data = 8'd200;
    @(negedge clk);
    chk("busy_load_ready", 64'(Load_Ready), 64'd0);
    chk("busy_no_we", 64'({En_Write_A, En_Write_B}), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    Start = 1'b0; Clear_Req = 1'b0; Load_Valid = 1'b0;
    begin
      int cyc;
      logic [ACCW-1:0] exp;
      cyc = 0;
      @(negedge clk);
      while (!Done && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      exp = exp_q.pop_front();
      if (!Done) chk("busy_timeout", 64'd0, 64'd1);
      else chk("busy_result", 64'(Result), 64'(exp));
    end
    chk("busy_no_write", 64'(wr_total - w0), 64'd0);
    chk("busy_no_clear", 64'(clr_total - c0), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_single_done", 64'(done_total - d0), 64'd1);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of READ
    Vec_Len = 5'd8; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_read", 64'({Chip_Select, En_Read, Read_Addr}), 64'd0);
    chk("abort_result", 64'(Result), 64'd0);
    chk("abort_done", 64'(Done), 64'd0);
    d0 = done_total;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
    end
    chk("abort_no_done", 64'(done_total - d0), 64'd0);
    chk("abort_idle", 64'(Busy), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
